// File: rtl/fpu_config_loader.sv
// Fetches a six-word FPU job configuration over a req/valid read port,
// stages it in shadow registers and commits every field in one cycle.
module fpu_config_loader #(
    parameter logic [31:0] CONFIG_BASE = 32'h0000_1000,
    parameter int unsigned WORD_BYTES  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_config_start,
    output logic              mem_read_req,
    output logic [31:0]       address_mem,
    input  logic              mapped_data_valid,
    input  logic [31:0]       data_mem,
    output logic              load_config_done,
    output logic              config_error,
    output logic signed [7:0] filter [0:8],
    output logic [15:0]       image_width,
    output logic [15:0]       image_height,
    output logic [31:0]       start_address,
    output logic [31:0]       result_address
);
    typedef enum logic [1:0] {IDLE, READ, COMMIT} state_t;

    localparam logic [2:0]  LAST_IDX = 3'd5;
    localparam logic [31:0] STRIDE   = 32'(WORD_BYTES);

    state_t            state_q;
    logic [2:0]        idx_q;
    logic              req_q;
    logic [31:0]       addr_q;
    logic              done_q;
    logic              error_q;

    logic signed [7:0] sh_filter_q [0:8];
    logic [15:0]       sh_width_q;
    logic [15:0]       sh_height_q;
    logic [31:0]       sh_start_q;
    logic [31:0]       sh_result_q;

    logic signed [7:0] filter_q [0:8];
    logic [15:0]       width_q;
    logic [15:0]       height_q;
    logic [31:0]       start_q;
    logic [31:0]       result_q;

    logic              cfg_bad;

    // A bad config is still committed; the flag only tells the FPU not to trust it.
    assign cfg_bad = (sh_width_q == '0) || (sh_height_q == '0) ||
                     (sh_start_q[1:0] != 2'b00) || (sh_result_q[1:0] != 2'b00);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            req_q       <= 1'b0;
            addr_q      <= '0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            sh_filter_q <= '{default: '0};
            sh_width_q  <= '0;
            sh_height_q <= '0;
            sh_start_q  <= '0;
            sh_result_q <= '0;
            filter_q    <= '{default: '0};
            width_q     <= '0;
            height_q    <= '0;
            start_q     <= '0;
            result_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (load_config_start) begin
                        state_q <= READ;
                        idx_q   <= '0;
                        req_q   <= 1'b1;
                        addr_q  <= CONFIG_BASE;
                        done_q  <= 1'b0;
                    end
                end
                READ: begin
                    if (mapped_data_valid) begin
                        case (idx_q)
                            3'd0: begin
                                sh_filter_q[0] <= data_mem[7:0];
                                sh_filter_q[1] <= data_mem[15:8];
                                sh_filter_q[2] <= data_mem[23:16];
                                sh_filter_q[3] <= data_mem[31:24];
                            end
                            3'd1: begin
                                sh_filter_q[4] <= data_mem[7:0];
                                sh_filter_q[5] <= data_mem[15:8];
                                sh_filter_q[6] <= data_mem[23:16];
                                sh_filter_q[7] <= data_mem[31:24];
                            end
                            3'd2: sh_filter_q[8] <= data_mem[7:0];
                            3'd3: begin
                                sh_width_q  <= data_mem[15:0];
                                sh_height_q <= data_mem[31:16];
                            end
                            3'd4: sh_start_q  <= data_mem;
                            3'd5: sh_result_q <= data_mem;
                            default: ;
                        endcase
                        if (idx_q == LAST_IDX) begin
                            state_q <= COMMIT;
                            req_q   <= 1'b0;
                            addr_q  <= '0;
                        end else begin
                            idx_q  <= idx_q + 3'd1;
                            addr_q <= addr_q + STRIDE;
                        end
                    end
                end
                COMMIT: begin
                    filter_q <= sh_filter_q;
                    width_q  <= sh_width_q;
                    height_q <= sh_height_q;
                    start_q  <= sh_start_q;
                    result_q <= sh_result_q;
                    error_q  <= cfg_bad;
                    done_q   <= 1'b1;
                    idx_q    <= '0;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_read_req     = req_q;
    assign address_mem      = addr_q;
    assign load_config_done = done_q;
    assign config_error     = error_q;
    assign filter           = filter_q;
    assign image_width      = width_q;
    assign image_height     = height_q;
    assign start_address    = start_q;
    assign result_address   = result_q;

endmodule

// File: tb/tb_fpu_config_loader.sv
// Directed bench for fpu_config_loader with a small req/valid memory responder.
module tb_fpu_config_loader;
    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              load_config_start = 1'b0;
    logic              mem_read_req;
    logic [31:0]       address_mem;
    logic              mapped_data_valid;
    logic [31:0]       data_mem;
    logic              load_config_done;
    logic              config_error;
    logic signed [7:0] filter [0:8];
    logic [15:0]       image_width;
    logic [15:0]       image_height;
    logic [31:0]       start_address;
    logic [31:0]       result_address;

    logic [31:0]       mem [0:5];
    int unsigned       max_delay = 0;
    int unsigned       cur_delay = 0;
    int unsigned       wait_cnt = 0;
    logic              spur_valid = 1'b0;

    logic [31:0]       addr_log [$];
    int                done_rises = 0;
    int                stab_err = 0;
    logic              prev_req = 1'b0;
    logic              prev_valid = 1'b0;
    logic              prev_done = 1'b0;
    logic [31:0]       prev_addr = '0;

    int                n_cmp = 0;
    int                n_fail = 0;

    localparam logic [168:0] EXP1 = {8'h01, 8'h02, 8'h03, 8'h04, 8'hFF, 8'hFE, 8'hFD, 8'hFC, 8'h05,
                                     16'd64, 16'd32, 32'h0001_0000, 32'h0002_0000, 1'b0};
    localparam logic [168:0] EXP3 = {8'h01, 8'h02, 8'h03, 8'h04, 8'hFF, 8'hFE, 8'hFD, 8'hFC, 8'h05,
                                     16'd64, 16'd0, 32'h0001_0002, 32'h0002_0000, 1'b1};

    fpu_config_loader #(
        .CONFIG_BASE(32'h0000_1000),
        .WORD_BYTES (4)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .load_config_start(load_config_start),
        .mem_read_req     (mem_read_req),
        .address_mem      (address_mem),
        .mapped_data_valid(mapped_data_valid),
        .data_mem         (data_mem),
        .load_config_done (load_config_done),
        .config_error     (config_error),
        .filter           (filter),
        .image_width      (image_width),
        .image_height     (image_height),
        .start_address    (start_address),
        .result_address   (result_address)
    );

    always #5 clk = ~clk;

    assign mapped_data_valid = spur_valid | (mem_read_req & (wait_cnt >= cur_delay));

    always_comb begin
        data_mem = 32'hDEAD_BEEF;
        for (int i = 0; i < 6; i++)
            if (address_mem == 32'h0000_1000 + 32'(4 * i)) data_mem = mem[i];
    end

    always @(posedge clk) begin
        if (mem_read_req && !mapped_data_valid) begin
            wait_cnt <= wait_cnt + 1;
        end else begin
            wait_cnt  <= 0;
            cur_delay <= (max_delay == 0) ? 0 : $urandom_range(max_delay, 0);
        end
    end

    // Records accepted reads, done rises and req/address stability while stalled.
    always @(posedge clk) begin
        if (!rst_n) begin
            prev_req   <= 1'b0;
            prev_valid <= 1'b0;
            prev_done  <= 1'b0;
        end else begin
            if (mem_read_req && mapped_data_valid) addr_log.push_back(address_mem);
            if (prev_req && !prev_valid && !(mem_read_req && address_mem == prev_addr))
                stab_err <= stab_err + 1;
            if (load_config_done && !prev_done) done_rises <= done_rises + 1;
            prev_req   <= mem_read_req;
            prev_valid <= mapped_data_valid;
            prev_done  <= load_config_done;
            prev_addr  <= address_mem;
        end
    end

    function automatic logic [168:0] cfg_now();
        return {filter[0], filter[1], filter[2], filter[3], filter[4], filter[5], filter[6],
                filter[7], filter[8], image_width, image_height, start_address, result_address,
                config_error};
    endfunction

    function automatic logic [31:0] log_at(input int i);
        return (i < addr_log.size()) ? addr_log[i] : 32'hFFFF_FFFF;
    endfunction

    task automatic load_mem(input logic [31:0] w3, input logic [31:0] w4);
        mem[0] = 32'h0403_0201;
        mem[1] = 32'hFCFD_FEFF;
        mem[2] = 32'h0000_0005;
        mem[3] = w3;
        mem[4] = w4;
        mem[5] = 32'h0002_0000;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 load_config_start = 1'b1;
        @(posedge clk); #1 load_config_start = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc, output int cyc);
        cyc = -1;
        for (int i = 1; i <= max_cyc; i++) begin
            @(posedge clk); #1;
            if (load_config_done) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (load_config_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", load_config_done); end
        n_cmp++; if (mem_read_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got=%b exp=0", mem_read_req); end
        n_cmp++; if (address_mem !== 32'h0) begin n_fail++; $display("FAIL reset_addr got=%h exp=0", address_mem); end
        n_cmp++; if (cfg_now() !== '0) begin n_fail++; $display("FAIL reset_cfg got=%h exp=0", cfg_now()); end
        rst_n = 1'b1;
    endtask

    task automatic test_zero_wait();
        int base;
        load_mem(32'h0020_0040, 32'h0001_0000);
        max_delay = 0;
        base = addr_log.size();
        pulse_start();
        repeat (6) @(posedge clk);
        #1;
        n_cmp++; if (load_config_done !== 1'b0) begin n_fail++; $display("FAIL zw_done_early got=%b exp=0", load_config_done); end
        @(posedge clk); #1;
        n_cmp++; if (load_config_done !== 1'b1) begin n_fail++; $display("FAIL zw_done_t7 got=%b exp=1", load_config_done); end
        n_cmp++; if (addr_log.size() - base !== 6) begin n_fail++; $display("FAIL zw_nreads got=%0d exp=6", addr_log.size() - base); end
        for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if (log_at(base + i) !== 32'h0000_1000 + 32'(4 * i)) begin
                n_fail++; $display("FAIL zw_addr%0d got=%h exp=%h", i, log_at(base + i), 32'h0000_1000 + 32'(4 * i));
            end
        end
        n_cmp++; if (cfg_now() !== EXP1) begin n_fail++; $display("FAIL zw_cfg got=%h exp=%h", cfg_now(), EXP1); end
        n_cmp++; if (mem_read_req !== 1'b0 || address_mem !== 32'h0) begin
            n_fail++; $display("FAIL zw_idle_port got=%b/%h exp=0/0", mem_read_req, address_mem);
        end
    endtask

    task automatic test_random_delay();
        int base, stab0, cyc;
        max_delay = 5;
        base  = addr_log.size();
        stab0 = stab_err;
        pulse_start();
        cyc = -1;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk); #1;
            if (load_config_done) begin
                cyc = i;
                break;
            end
            n_cmp++; if (cfg_now() !== EXP1) begin n_fail++; $display("FAIL rd_held_cyc%0d got=%h exp=%h", i, cfg_now(), EXP1); end
        end
        n_cmp++; if (cyc < 7) begin n_fail++; $display("FAIL rd_done_cycles got=%0d exp=7..100", cyc); end
        n_cmp++; if (stab_err !== stab0) begin n_fail++; $display("FAIL rd_stable got=%0d exp=%0d", stab_err, stab0); end
        n_cmp++; if (addr_log.size() - base !== 6) begin n_fail++; $display("FAIL rd_nreads got=%0d exp=6", addr_log.size() - base); end
        for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if (log_at(base + i) !== 32'h0000_1000 + 32'(4 * i)) begin
                n_fail++; $display("FAIL rd_addr%0d got=%h exp=%h", i, log_at(base + i), 32'h0000_1000 + 32'(4 * i));
            end
        end
        n_cmp++; if (cfg_now() !== EXP1) begin n_fail++; $display("FAIL rd_cfg got=%h exp=%h", cfg_now(), EXP1); end
        max_delay = 0;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_error_config();
        int cyc;
        load_mem(32'h0000_0040, 32'h0001_0002);
        pulse_start();
        wait_done(50, cyc);
        n_cmp++; if (cyc !== 7) begin n_fail++; $display("FAIL err_latency got=%0d exp=7", cyc); end
        n_cmp++; if (config_error !== 1'b1) begin n_fail++; $display("FAIL err_flag got=%b exp=1", config_error); end
        n_cmp++; if (image_height !== 16'd0) begin n_fail++; $display("FAIL err_height got=%0d exp=0", image_height); end
        n_cmp++; if (start_address !== 32'h0001_0002) begin n_fail++; $display("FAIL err_start got=%h exp=00010002", start_address); end
        n_cmp++; if (cfg_now() !== EXP3) begin n_fail++; $display("FAIL err_cfg got=%h exp=%h", cfg_now(), EXP3); end
    endtask

    task automatic test_restart_ignored();
        int base, rises0, cyc;
        load_mem(32'h0020_0040, 32'h0001_0000);
        repeat (2) @(posedge clk);
        base   = addr_log.size();
        rises0 = done_rises;
        pulse_start();
        repeat (3) @(posedge clk);
        #1 load_config_start = 1'b1;
        n_cmp++; if (load_config_done !== 1'b0) begin n_fail++; $display("FAIL rs_done_mid got=%b exp=0", load_config_done); end
        n_cmp++; if (cfg_now() !== EXP3) begin n_fail++; $display("FAIL rs_atomic got=%h exp=%h", cfg_now(), EXP3); end
        @(posedge clk); #1 load_config_start = 1'b0;
        wait_done(50, cyc);
        n_cmp++; if (cyc < 0) begin n_fail++; $display("FAIL rs_done_timeout got=%0d exp>0", cyc); end
        repeat (10) @(posedge clk);
        #1;
        n_cmp++; if (addr_log.size() - base !== 6) begin n_fail++; $display("FAIL rs_nreads got=%0d exp=6", addr_log.size() - base); end
        n_cmp++; if (done_rises - rises0 !== 1) begin n_fail++; $display("FAIL rs_rises got=%0d exp=1", done_rises - rises0); end
        n_cmp++; if (mem_read_req !== 1'b0) begin n_fail++; $display("FAIL rs_req_idle got=%b exp=0", mem_read_req); end
        n_cmp++; if (cfg_now() !== EXP1) begin n_fail++; $display("FAIL rs_cfg got=%h exp=%h", cfg_now(), EXP1); end
    endtask

    task automatic test_reset_mid_fetch();
        int base, cyc;
        pulse_start();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        n_cmp++; if (load_config_done !== 1'b0 || config_error !== 1'b0) begin
            n_fail++; $display("FAIL mr_flags got=%b/%b exp=0/0", load_config_done, config_error);
        end
        n_cmp++; if (mem_read_req !== 1'b0 || address_mem !== 32'h0) begin
            n_fail++; $display("FAIL mr_port got=%b/%h exp=0/0", mem_read_req, address_mem);
        end
        n_cmp++; if (cfg_now() !== '0) begin n_fail++; $display("FAIL mr_cfg got=%h exp=0", cfg_now()); end
        @(posedge clk); #1 rst_n = 1'b1;
        base = addr_log.size();
        pulse_start();
        wait_done(50, cyc);
        n_cmp++; if (cyc !== 7) begin n_fail++; $display("FAIL mr_latency got=%0d exp=7", cyc); end
        n_cmp++; if (log_at(base) !== 32'h0000_1000) begin n_fail++; $display("FAIL mr_first_addr got=%h exp=00001000", log_at(base)); end
        n_cmp++; if (addr_log.size() - base !== 6) begin n_fail++; $display("FAIL mr_nreads got=%0d exp=6", addr_log.size() - base); end
        n_cmp++; if (cfg_now() !== EXP1) begin n_fail++; $display("FAIL mr_cfg_after got=%h exp=%h", cfg_now(), EXP1); end
    endtask

    task automatic test_spurious_valid();
        int base, cyc;
        load_mem(32'h0000_0040, 32'h0001_0002);
        pulse_start();
        wait_done(50, cyc);
        n_cmp++; if (cfg_now() !== EXP3) begin n_fail++; $display("FAIL sp_pre_cfg got=%h exp=%h", cfg_now(), EXP3); end
        load_mem(32'h0020_0040, 32'h0001_0000);
        base = addr_log.size();
        @(posedge clk); #1 spur_valid = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        n_cmp++; if (mem_read_req !== 1'b0) begin n_fail++; $display("FAIL sp_req got=%b exp=0", mem_read_req); end
        n_cmp++; if (load_config_done !== 1'b1) begin n_fail++; $display("FAIL sp_done got=%b exp=1", load_config_done); end
        n_cmp++; if (addr_log.size() !== base) begin n_fail++; $display("FAIL sp_no_read got=%0d exp=%0d", addr_log.size(), base); end
        n_cmp++; if (cfg_now() !== EXP3) begin n_fail++; $display("FAIL sp_no_capture got=%h exp=%h", cfg_now(), EXP3); end
        spur_valid = 1'b0;
        pulse_start();
        wait_done(50, cyc);
        n_cmp++; if (cyc !== 7) begin n_fail++; $display("FAIL sp_latency got=%0d exp=7", cyc); end
        n_cmp++; if (cfg_now() !== EXP1) begin n_fail++; $display("FAIL sp_cfg got=%h exp=%h", cfg_now(), EXP1); end
    endtask

    initial begin
        load_mem(32'h0020_0040, 32'h0001_0000);
        test_reset();
        test_zero_wait();
        test_random_delay();
        test_error_config();
        test_restart_ignored();
        test_reset_mid_fetch();
        test_spurious_valid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "simulation time limit reached");
    end

endmodule
